// File: rtl/controlador_nota.sv
// Song-playback controller and arbiter for the piano tone path: passes free-play notes through
// when idle, and on request plays a fixed internal song ROM timed in tempo ticks.
module controlador_nota #(
  parameter int unsigned LARGO    = 16,
  parameter int unsigned PAUSA    = 1,
  parameter logic [2:0]  SILENCIO = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       inicio_cancion,
  input  logic       detener,
  input  logic [2:0] nota_libre,
  input  logic       contar_libre,
  output logic [2:0] nota_salida,
  output logic       sonar,
  output logic       ocupado,
  output logic       fin_cancion,
  output logic [4:0] indice
);

  typedef enum logic [2:0] {StEspera, StCarga, StToca, StPausa, StFin} estado_e;

  localparam logic [4:0] Ultimo     = 5'(LARGO - 1);
  localparam logic [2:0] PausaTicks = 3'(PAUSA);

  // Entry format {nota, dur}; nota == 0 marks the end of the song.
  function automatic logic [5:0] rom(input logic [4:0] dir);
    case (dir)
      5'd0:    rom = {3'd1, 3'd2};
      5'd1:    rom = {3'd2, 3'd2};
      5'd2:    rom = {3'd3, 3'd2};
      5'd3:    rom = {3'd1, 3'd2};
      5'd4:    rom = {3'd4, 3'd4};
      default: rom = 6'd0;
    endcase
  endfunction

  estado_e    estado_q, estado_d;
  logic [4:0] indice_q, indice_d;
  logic [2:0] cuenta_q, cuenta_d;
  logic [2:0] nota_q, nota_d;
  logic       sonar_q, sonar_d;
  logic       ocupado_q, ocupado_d;
  logic       fin_q, fin_d;

  logic [5:0] entrada;
  logic [2:0] nota_rom;
  logic [2:0] dur_rom;
  logic       avanzar;

  always_comb begin
    estado_d = estado_q;
    indice_d = indice_q;
    cuenta_d = cuenta_q;
    avanzar  = 1'b0;
    entrada  = rom(indice_q);
    nota_rom = entrada[5:3];
    dur_rom  = entrada[2:0];

    unique case (estado_q)
      StEspera: begin
        if (inicio_cancion) begin
          estado_d = StCarga;
          indice_d = 5'd0;
        end
      end
      StCarga: begin
        if (nota_rom == 3'd0) begin
          estado_d = StFin;
        end else begin
          cuenta_d = (dur_rom == 3'd0) ? 3'd1 : dur_rom;
          estado_d = StToca;
        end
      end
      StToca: begin
        if (tick) begin
          if (cuenta_q == 3'd1) begin
            if (PAUSA > 0) begin
              cuenta_d = PausaTicks;
              estado_d = StPausa;
            end else begin
              avanzar = 1'b1;
            end
          end else begin
            cuenta_d = cuenta_q - 3'd1;
          end
        end
      end
      StPausa: begin
        if (tick) begin
          if (cuenta_q == 3'd1) avanzar = 1'b1;
          else                  cuenta_d = cuenta_q - 3'd1;
        end
      end
      StFin: begin
        estado_d = StEspera;
        indice_d = 5'd0;
      end
      default: estado_d = StEspera;
    endcase

    // The index saturates at the last entry instead of wrapping.
    if (avanzar) begin
      cuenta_d = 3'd0;
      if (indice_q == Ultimo) begin
        estado_d = StFin;
      end else begin
        indice_d = indice_q + 5'd1;
        estado_d = StCarga;
      end
    end

    if (detener) begin
      estado_d = StEspera;
      indice_d = 5'd0;
      cuenta_d = 3'd0;
    end
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    nota_d    = SILENCIO;
    sonar_d   = 1'b0;
    ocupado_d = (estado_d != StEspera);
    fin_d     = (estado_d == StFin);
    case (estado_d)
      StEspera: begin
        if (!detener && contar_libre) begin
          nota_d  = nota_libre;
          sonar_d = 1'b1;
        end
      end
      StToca: begin
        nota_d  = nota_rom;
        sonar_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= StEspera;
      indice_q  <= 5'd0;
      cuenta_q  <= 3'd0;
      nota_q    <= 3'd7;
      sonar_q   <= 1'b0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      indice_q  <= indice_d;
      cuenta_q  <= cuenta_d;
      nota_q    <= nota_d;
      sonar_q   <= sonar_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end
  end

  assign nota_salida = nota_q;
  assign sonar       = sonar_q;
  assign ocupado     = ocupado_q;
  assign fin_cancion = fin_q;
  assign indice      = indice_q;

endmodule

// File: doc/controlador_nota.md
# controlador_nota

Song-playback controller and arbiter for the shared note/tone path of the keyboard piano. It sits between the free-play FSM, which supplies a note code plus its count-enable, and the tone generator, which consumes a 3-bit note code plus a sound enable. When idle it passes free-play notes straight through. On request it takes ownership of the tone path and steps through a fixed internal song ROM, timing each note and inter-note gap in tempo ticks.

## Interface
- `LARGO`, default 16: number of ROM entries, 1..32.
- `PAUSA`, default 1: silence gap between notes, in ticks, 0..7.
- `SILENCIO`, default 3'd7: note code that means "no note".

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  tempo pulse, one cycle wide.
- `inicio_cancion`  in  1  start-song request, level-sampled.
- `detener`  in  1  abort request, level-sampled.
- `nota_libre`  in  3  note code from free-play mode.
- `contar_libre`  in  1  free-play note active.
- `nota_salida`  out  3  note code to the tone generator.
- `sonar`  out  1  tone generator enable.
- `ocupado`  out  1  song in progress.
- `fin_cancion`  out  1  one-cycle pulse when a song completes normally.
- `indice`  out  5  current ROM address.

## Operation
- ROM entry format is {nota[2:0], dur[2:0]}.
  - `nota`=0 marks end of song.
  - `dur`=0 is treated as 1.
- ROM contents:
  - Entries 0..5: (1,2) (2,2) (3,2) (1,2) (4,4) (0,0).
  - All remaining entries: (0,0).
- States: ESPERA, CARGA, TOCA, PAUSA, FIN.
- ESPERA:
  - `nota_salida` = `contar_libre` ? `nota_libre` : `SILENCIO`.
  - `sonar` = `contar_libre`.
  - `ocupado`=0.
  - If `inicio_cancion` is high, go to CARGA with `indice`=0.
- CARGA (1 cycle):
  - Read ROM[`indice`].
  - If `nota`==0, go to FIN.
  - Otherwise load the counter with `dur` (0 becomes 1) and go to TOCA.
- TOCA:
  - `nota_salida`=ROM `nota`, `sonar`=1.
  - Each `tick` decrements the counter.
  - On a `tick` with counter==1:
    - If `PAUSA`>0, load `PAUSA` and go to PAUSA.
    - Otherwise go to ADVANCE (below).
- PAUSA:
  - `nota_salida`=`SILENCIO`, `sonar`=0.
  - On a `tick` with counter==1, go to ADVANCE.
- ADVANCE (an action, not a state):
  - If `indice`==`LARGO`-1, go to FIN.
  - Otherwise increment `indice` and go to CARGA.
  - `indice` never wraps.
- FIN:
  - `fin_cancion`=1 for exactly one cycle.
  - Then go to ESPERA with `indice`=0.
- `ocupado`=1 in CARGA, TOCA, PAUSA and FIN.
- Free-play input is ignored while `ocupado`=1.
- `detener` has top priority:
  - From any state other than ESPERA, the next edge goes to ESPERA.
  - Clears `indice` and the counter, forces `sonar`=0 and `nota_salida`=`SILENCIO`.
  - No `fin_cancion` pulse.
  - In ESPERA, `detener` together with `inicio_cancion` means the controller stays in ESPERA.
- `inicio_cancion` is ignored while `ocupado`=1; there is no restart.
- `tick` is ignored in ESPERA, CARGA and FIN.

## Timing
- All outputs are registered. They take their next-state values on each rising `clk`.
- Reset (`reset`=0, asynchronous), all immediate:
  - State = ESPERA.
  - `nota_salida`=3'd7, `sonar`=0, `ocupado`=0, `fin_cancion`=0.
  - `indice`=0, counter=0.
- Release of reset is synchronous to the next edge.
- Reset asserted mid-song takes effect immediately. No `fin_cancion` pulse.
- Passthrough latency in ESPERA: 1 cycle from `nota_libre`/`contar_libre` to the outputs.
- Song start:
  - `inicio_cancion` is sampled at edge k.
  - `ocupado`=1 after edge k.
  - First note is on `nota_salida` with `sonar`=1 after edge k+1.
- A note sounds for exactly `dur` ticks. The gap lasts exactly `PAUSA` ticks plus one CARGA cycle.
- A `tick` arriving in the same cycle as the TOCA→PAUSA or PAUSA→CARGA transition is consumed by that transition. It is not carried forward.
- `fin_cancion` rises one edge after CARGA reads the end marker. `ocupado` falls on the following edge.

## Test plan
- Reset: hold `reset`=0 and toggle inputs. Outputs stay at 7/0/0/0 and `indice`=0. Pulse `reset` low mid-TOCA: `sonar` drops to 0 asynchronously.
- Passthrough: in ESPERA, apply `nota_libre`=3, `contar_libre`=1. Next cycle `nota_salida`=3, `sonar`=1. Set `contar_libre`=0: `nota_salida`=7, `sonar`=0.
- Full song, `tick` every 4 cycles, `PAUSA`=1:
  - Expected `nota_salida` sequence: 1,7,2,7,3,7,1,7,4,7.
  - Sounding lengths: 2,2,2,2,4 ticks.
  - Then `fin_cancion` pulses once and `ocupado` falls. `indice` returns to 0.
- Abort: assert `detener` during the third note (`indice`=2). Next cycle: ESPERA, `sonar`=0, `indice`=0, no `fin_cancion`. Free-play passthrough resumes.
- Arbitration: hold `contar_libre`=1, `nota_libre`=4, and pulse `inicio_cancion`. `ocupado`=1 and the song's note 1 is output, with 4 ignored. Pulse `inicio_cancion` again mid-song: no effect. `inicio_cancion`+`detener` together in ESPERA: remains in ESPERA.
- Boundary, `LARGO`=4 with `PAUSA`=0: playback stops after entry 3 with no wrap to 0. `fin_cancion` pulses once, and every note is followed directly by a one-cycle CARGA.
